// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter slice.
//   ADDR_W / DATA_W / BE_W : geometry of the 8K x 32 byte-enabled SRAM.
//   STREAK_W               : width of the D-grant streak counter (MAX_D_STREAK <= 15).
//   tag_t                  : owner tag carried alongside each in-flight SRAM read.
//   rd_tag()               : tag to launch into the response pipe for a grant.
package sram_arb_pkg;

    localparam int ADDR_W   = 13;
    localparam int DATA_W   = 32;
    localparam int BE_W     = 4;
    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_I    = 2'd1,
        TAG_D    = 2'd2
    } tag_t;

    // Only reads produce a response; a D write launches an empty slot so the
    // pipe keeps shifting at a fixed rate.
    function automatic tag_t rd_tag(input logic i_g, input logic d_g, input logic d_we);
        tag_t t;
        t = TAG_NONE;
        if (i_g) begin
            t = TAG_I;
        end else if (d_g && !d_we) begin
            t = TAG_D;
        end
        return t;
    endfunction

endpackage

// File: rtl/sram_rsp_pipe.sv
// Response steering for the SRAM arbiter.
// Carries an owner tag per issued access through a RD_LATENCY-deep shift
// register so that the tag leaves the pipe in the same cycle the SRAM
// presents the matching word on sram_q.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   tag_in              : tag for the access issued this cycle (TAG_NONE if none)
//   sram_q              : SRAM read data
//   i_rvalid / i_rdata  : fetch response (rdata holds the last returned word)
//   d_rvalid / d_rdata  : load response  (rdata holds the last returned word)
module sram_rsp_pipe
    import sram_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1    // legal 1..3
)(
    input  logic              clk,
    input  logic              rst,
    input  tag_t              tag_in,
    input  logic [DATA_W-1:0] sram_q,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata
);

    tag_t              stage_reg [RD_LATENCY];
    tag_t              tag_out;
    logic              i_hit;
    logic              d_hit;
    logic [DATA_W-1:0] i_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;

    // Reset empties the pipe, which is what drops in-flight reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                stage_reg[k] <= TAG_NONE;
            end
        end else begin
            stage_reg[0] <= tag_in;
            for (int k = 1; k < RD_LATENCY; k++) begin
                stage_reg[k] <= stage_reg[k-1];
            end
        end
    end

    assign tag_out = stage_reg[RD_LATENCY-1];
    assign i_hit   = (tag_out == TAG_I);
    assign d_hit   = (tag_out == TAG_D);

    // The word is on sram_q during the hit cycle itself; it is passed straight
    // through and captured so the port keeps showing it afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rdata_reg <= '0;
            d_rdata_reg <= '0;
        end else begin
            if (i_hit) begin
                i_rdata_reg <= sram_q;
            end
            if (d_hit) begin
                d_rdata_reg <= sram_q;
            end
        end
    end

    assign i_rvalid = i_hit;
    assign d_rvalid = d_hit;
    assign i_rdata  = i_hit ? sram_q : i_rdata_reg;
    assign d_rdata  = d_hit ? sram_q : d_rdata_reg;

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the single-port 8K x 32 byte-enabled SRAM.
// The fetch port (I, read-only) and load/store port (D, read/write) compete
// every cycle; D wins unless it has already taken MAX_D_STREAK grants in a
// row while I was waiting. The winner drives the SRAM pins in the same cycle
// and read data is steered back by sram_rsp_pipe.
// Ports:
//   clk, rst                                  : clock, asynchronous active-high reset
//   i_req, i_addr -> i_gnt, i_rvalid, i_rdata : fetch port
//   d_req, d_we, d_addr, d_byteen, d_wdata
//                 -> d_gnt, d_rvalid, d_rdata : load/store port
//   sram_addr, sram_byteen, sram_data,
//   sram_rden, sram_wren, sram_q              : SRAM pins
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int RD_LATENCY   = 1, // SRAM read latency, legal 1..3
    parameter int MAX_D_STREAK = 4  // legal 1..15
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [BE_W-1:0]   d_byteen,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [BE_W-1:0]   sram_byteen,
    output logic [DATA_W-1:0] sram_data,
    output logic              sram_rden,
    output logic              sram_wren,
    input  logic [DATA_W-1:0] sram_q
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    logic [STREAK_W-1:0] streak_reg;
    logic [STREAK_W-1:0] streak_next;
    logic                i_starved;
    logic [ADDR_W-1:0]   addr_reg;
    logic [BE_W-1:0]     byteen_reg;
    logic [DATA_W-1:0]   data_reg;
    tag_t                launch_tag;

    // ------------------------------------------------------------------
    // Grant. Reset is folded in so no grant or SRAM strobe can leak out
    // while rst is high, even though the request inputs may still be set.
    // ------------------------------------------------------------------
    always_comb begin
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        i_starved = i_req && (streak_reg == STREAK_MAX);
        if (!rst) begin
            if (d_req && !i_starved) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    // Streak counts D wins only while I is actually waiting; any cycle
    // without an I request breaks the streak.
    always_comb begin
        streak_next = streak_reg;
        if (!i_req || i_gnt) begin
            streak_next = '0;
        end else if (d_gnt && (streak_reg != STREAK_MAX)) begin
            streak_next = streak_reg + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_reg <= '0;
        end else begin
            streak_reg <= streak_next;
        end
    end

    // ------------------------------------------------------------------
    // SRAM drive. Address/byteen/data fall back to the last driven values
    // on idle cycles so the pins do not toggle needlessly.
    // ------------------------------------------------------------------
    always_comb begin
        sram_addr   = addr_reg;
        sram_byteen = byteen_reg;
        sram_data   = data_reg;
        sram_rden   = 1'b0;
        sram_wren   = 1'b0;
        if (i_gnt) begin
            sram_addr   = i_addr;
            sram_byteen = '1;
            sram_rden   = 1'b1;
        end else if (d_gnt) begin
            sram_addr   = d_addr;
            sram_byteen = d_byteen;
            sram_data   = d_wdata;
            sram_wren   = d_we;
            sram_rden   = !d_we;
        end
    end

    // Capturing the driven values every cycle is equivalent to loading on a
    // grant, because on idle cycles the pins already show the held values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg   <= '0;
            byteen_reg <= '0;
            data_reg   <= '0;
        end else begin
            addr_reg   <= sram_addr;
            byteen_reg <= sram_byteen;
            data_reg   <= sram_data;
        end
    end

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    assign launch_tag = rd_tag(i_gnt, d_gnt, d_we);

    sram_rsp_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rsp_pipe (
        .clk      (clk),
        .rst      (rst),
        .tag_in   (launch_tag),
        .sram_q   (sram_q),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: one instance with RD_LATENCY=1 and one with
// RD_LATENCY=2 share the same request stimulus, each with its own SRAM model.
// A reference model (arbitration rule, shadow memory, expected-response
// queues) checks grants, SRAM pins and responses every cycle.
module tb_sram_arbiter;

    localparam int MAXS = 4;
    localparam int LAT0 = 1;
    localparam int LAT1 = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [12:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [12:0] d_addr;
    logic [3:0]  d_byteen;
    logic [31:0] d_wdata;

    logic [1:0]  i_gnt_w, d_gnt_w, i_rv_w, d_rv_w, s_rden, s_wren;
    logic [31:0] i_rd_w [2];
    logic [31:0] d_rd_w [2];
    logic [12:0] s_addr [2];
    logic [3:0]  s_be   [2];
    logic [31:0] s_data [2];
    logic [31:0] s_q    [2];

    always #5 clk = ~clk;

    sram_arbiter #(.RD_LATENCY(LAT0), .MAX_D_STREAK(MAXS)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_w[0]),
        .i_rvalid(i_rv_w[0]), .i_rdata(i_rd_w[0]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_byteen(d_byteen),
        .d_wdata(d_wdata), .d_gnt(d_gnt_w[0]),
        .d_rvalid(d_rv_w[0]), .d_rdata(d_rd_w[0]),
        .sram_addr(s_addr[0]), .sram_byteen(s_be[0]), .sram_data(s_data[0]),
        .sram_rden(s_rden[0]), .sram_wren(s_wren[0]), .sram_q(s_q[0])
    );

    sram_arbiter #(.RD_LATENCY(LAT1), .MAX_D_STREAK(MAXS)) u_dut_l2 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_w[1]),
        .i_rvalid(i_rv_w[1]), .i_rdata(i_rd_w[1]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_byteen(d_byteen),
        .d_wdata(d_wdata), .d_gnt(d_gnt_w[1]),
        .d_rvalid(d_rv_w[1]), .d_rdata(d_rd_w[1]),
        .sram_addr(s_addr[1]), .sram_byteen(s_be[1]), .sram_data(s_data[1]),
        .sram_rden(s_rden[1]), .sram_wren(s_wren[1]), .sram_q(s_q[1])
    );

    // ---------------- SRAM models (one per instance) ----------------
    logic [31:0] mem [2][8192];
    logic [31:0] qp  [2][2];
    logic [31:0] wr_word;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (s_wren[k]) begin
                wr_word = mem[k][s_addr[k]];
                for (int b = 0; b < 4; b++) begin
                    if (s_be[k][b]) wr_word[8*b +: 8] = s_data[k][8*b +: 8];
                end
                mem[k][s_addr[k]] <= wr_word;
            end
            if (s_rden[k]) qp[k][0] <= mem[k][s_addr[k]];
            qp[k][1] <= qp[k][0];
        end
    end

    assign s_q[0] = qp[0][LAT0-1];
    assign s_q[1] = qp[1][LAT1-1];

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        bit          is_d;
        logic [31:0] data;
    } rsp_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          d_run = 0;
    int          lat [2] = '{LAT0, LAT1};
    logic [31:0] shadow [8192];
    rsp_t        rq [2][$];
    logic [31:0] last_i [2];
    logic [31:0] last_d [2];
    logic [12:0] last_addr;
    logic [3:0]  last_be;
    bit          i_granted = 0;
    bit          d_granted = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            rq[k].delete();
            last_i[k] = '0;
            last_d[k] = '0;
        end
        d_run     = 0;
        last_addr = '0;
        last_be   = '0;
        i_granted = 0;
        d_granted = 0;
    endtask

    // Called at the falling edge: compares everything, then advances the model.
    task automatic sample();
        bit          exp_i, exp_d, exp_iv, exp_dv;
        rsp_t        r;
        logic [31:0] w;
        exp_i = 0;
        exp_d = 0;
        if (rst) begin
            model_reset();
        end else if (i_req && d_run == MAXS) begin
            exp_i = 1;
        end else if (d_req) begin
            exp_d = 1;
        end else if (i_req) begin
            exp_i = 1;
        end

        for (int k = 0; k < 2; k++) begin
            check($sformatf("L%0d i_gnt", lat[k]), 32'(i_gnt_w[k]), 32'(exp_i));
            check($sformatf("L%0d d_gnt", lat[k]), 32'(d_gnt_w[k]), 32'(exp_d));
            exp_iv = 0;
            exp_dv = 0;
            if (rq[k].size() != 0 && rq[k][0].due == cyc) begin
                r = rq[k].pop_front();
                if (r.is_d) begin
                    exp_dv    = 1;
                    last_d[k] = r.data;
                end else begin
                    exp_iv    = 1;
                    last_i[k] = r.data;
                end
            end
            check($sformatf("L%0d i_rvalid", lat[k]), 32'(i_rv_w[k]), 32'(exp_iv));
            check($sformatf("L%0d d_rvalid", lat[k]), 32'(d_rv_w[k]), 32'(exp_dv));
            check($sformatf("L%0d i_rdata", lat[k]), i_rd_w[k], last_i[k]);
            check($sformatf("L%0d d_rdata", lat[k]), d_rd_w[k], last_d[k]);
            if (exp_i) begin
                check($sformatf("L%0d sram_addr", lat[k]), 32'(s_addr[k]), 32'(i_addr));
                check($sformatf("L%0d sram_byteen", lat[k]), 32'(s_be[k]), 32'hf);
                check($sformatf("L%0d sram_rden", lat[k]), 32'(s_rden[k]), 32'd1);
                check($sformatf("L%0d sram_wren", lat[k]), 32'(s_wren[k]), 32'd0);
            end else if (exp_d) begin
                check($sformatf("L%0d sram_addr", lat[k]), 32'(s_addr[k]), 32'(d_addr));
                check($sformatf("L%0d sram_byteen", lat[k]), 32'(s_be[k]), 32'(d_byteen));
                check($sformatf("L%0d sram_rden", lat[k]), 32'(s_rden[k]), 32'(!d_we));
                check($sformatf("L%0d sram_wren", lat[k]), 32'(s_wren[k]), 32'(d_we));
                if (d_we) check($sformatf("L%0d sram_data", lat[k]), s_data[k], d_wdata);
            end else begin
                check($sformatf("L%0d idle rden", lat[k]), 32'(s_rden[k]), 32'd0);
                check($sformatf("L%0d idle wren", lat[k]), 32'(s_wren[k]), 32'd0);
                check($sformatf("L%0d idle addr", lat[k]), 32'(s_addr[k]), 32'(last_addr));
                check($sformatf("L%0d idle byteen", lat[k]), 32'(s_be[k]), 32'(last_be));
            end
        end

        if (!rst) begin
            if (exp_i) begin
                $display("[TB] cyc %0d I rd  addr %h exp %h", cyc, i_addr, shadow[i_addr]);
                for (int k = 0; k < 2; k++) rq[k].push_back('{cyc + lat[k], 1'b0, shadow[i_addr]});
                last_addr = i_addr;
                last_be   = 4'hf;
            end else if (exp_d) begin
                last_addr = d_addr;
                last_be   = d_byteen;
                if (d_we) begin
                    $display("[TB] cyc %0d D wr  addr %h be %b data %h", cyc, d_addr, d_byteen, d_wdata);
                    w = shadow[d_addr];
                    for (int b = 0; b < 4; b++) begin
                        if (d_byteen[b]) w[8*b +: 8] = d_wdata[8*b +: 8];
                    end
                    shadow[d_addr] = w;
                end else begin
                    $display("[TB] cyc %0d D rd  addr %h exp %h", cyc, d_addr, shadow[d_addr]);
                    for (int k = 0; k < 2; k++) rq[k].push_back('{cyc + lat[k], 1'b1, shadow[d_addr]});
                end
            end
            if (!i_req || exp_i) d_run = 0;
            else if (exp_d && d_run < MAXS) d_run++;
            i_granted = exp_i;
            d_granted = exp_d;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        advance();
    endtask

    task automatic set_d(input bit req, input bit we, input logic [12:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        d_req    = req;
        d_we     = we;
        d_addr   = a;
        d_byteen = be;
        d_wdata  = wd;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 8192; a++) mem[k][a] = '0;
        end
        for (int a = 0; a < 8192; a++) shadow[a] = '0;
        model_reset();
        rst    = 1'b1;
        i_req  = 1'b0;
        i_addr = '0;
        set_d(0, 0, 13'h0, 4'h0, 32'h0);
        #1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // D write then D read of 0x000
        set_d(1, 1, 13'h000, 4'b1111, 32'h12345678); tick();
        set_d(1, 0, 13'h000, 4'b1111, 32'h0);        tick();
        set_d(0, 0, 13'h000, 4'b0000, 32'h0);        tick(); tick();
        check("t1 d_rdata", d_rd_w[0], 32'h12345678);

        // Partial-byte writes merge, then fetch sees the merged word
        set_d(1, 1, 13'h000, 4'b1100, 32'h9876dead); tick();
        set_d(1, 1, 13'h000, 4'b0011, 32'hdead5432); tick();
        set_d(0, 0, 13'h000, 4'b0000, 32'h0);
        i_req = 1; i_addr = 13'h000;                  tick();
        i_req = 0;                                    tick(); tick(); tick();
        check("t2 i_rdata L1", i_rd_w[0], 32'h98765432);
        check("t2 i_rdata L2", i_rd_w[1], 32'h98765432);

        // Back-to-back I/D/I reads
        set_d(1, 1, 13'h001, 4'b1111, 32'h12345678); tick();
        set_d(0, 0, 13'h000, 4'b0000, 32'h0);
        i_req = 1; i_addr = 13'h001;                  tick();
        i_req = 0; set_d(1, 0, 13'h000, 4'b1111, 32'h0); tick();
        set_d(0, 0, 13'h000, 4'b0000, 32'h0);
        i_req = 1; i_addr = 13'h001;                  tick();
        i_req = 0;                                    tick(); tick(); tick();
        check("t4 i_rdata", i_rd_w[0], 32'h12345678);
        check("t4 d_rdata", d_rd_w[0], 32'h98765432);

        // Both requesting continuously: D,D,D,D,I repeating
        i_req = 1; i_addr = 13'h001;
        set_d(1, 0, 13'h000, 4'b1111, 32'h0);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check("t3 pattern i_gnt", 32'(i_gnt_w[0]), 32'(n % 5 == 4));
            sample();
            advance();
        end
        i_req = 0;
        set_d(0, 0, 13'h000, 4'b0000, 32'h0);
        tick(); tick(); tick();

        // Reset right after a D read grant drops the read
        set_d(1, 0, 13'h000, 4'b1111, 32'h0);
        @(negedge clk);
        sample();
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t5 L%0d d_gnt", lat[k]), 32'(d_gnt_w[k]), 32'd0);
            check($sformatf("t5 L%0d rden", lat[k]), 32'(s_rden[k]), 32'd0);
            check($sformatf("t5 L%0d addr", lat[k]), 32'(s_addr[k]), 32'd0);
            check($sformatf("t5 L%0d d_rvalid", lat[k]), 32'(d_rv_w[k]), 32'd0);
            check($sformatf("t5 L%0d d_rdata", lat[k]), d_rd_w[k], 32'd0);
        end
        model_reset();
        advance();
        tick();
        rst = 1'b0;
        tick();
        set_d(0, 0, 13'h000, 4'b0000, 32'h0);
        tick(); tick(); tick();

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            if (!i_req || i_granted) begin
                i_req  = ($urandom_range(0, 9) < 6);
                i_addr = 13'($urandom_range(0, 15));
            end
            if (!d_req || d_granted) begin
                set_d($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                      13'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
            end
            tick();
        end
        i_req = 0;
        set_d(0, 0, 13'h000, 4'b0000, 32'h0);
        for (int n = 0; n < 5; n++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
